// File: rtl/tl_state_seq_pkg.sv
// ============================================================================
// tl_state_seq_pkg : state encoding and default timing for the left-turn light
// Revision 1.0
// ============================================================================
`default_nettype none

package tl_state_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S0 = 3'b000;  // A green
    localparam state_t S1 = 3'b001;  // A yellow
    localparam state_t S2 = 3'b010;  // A left green
    localparam state_t S3 = 3'b011;  // A left yellow
    localparam state_t S4 = 3'b100;  // B green
    localparam state_t S5 = 3'b101;  // B yellow
    localparam state_t S6 = 3'b110;  // B left green
    localparam state_t S7 = 3'b111;  // B left yellow

    localparam int DEF_MIN_GREEN  = 4;
    localparam int DEF_MAX_GREEN  = 16;
    localparam int DEF_YEL_CYCLES = 2;
    localparam int DEF_CNT_W      = 5;

    // Every odd encoding is a yellow phase.
    function automatic logic is_yellow(input state_t s);
        return s[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl_dwell_cnt.sv
// ============================================================================
// tl_dwell_cnt : saturating per-state dwell counter, cleared on state change
// Revision 1.0
// ============================================================================
`default_nettype none

module tl_dwell_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/tl_state_seq.sv
// ============================================================================
// tl_state_seq : next-state logic, state register and dwell timing for the
//                left-turn traffic light controller
// Revision 1.0
// ============================================================================
`default_nettype none

module tl_state_seq
    import tl_state_seq_pkg::*;
#(
    parameter int MIN_GREEN  = DEF_MIN_GREEN,
    parameter int MAX_GREEN  = DEF_MAX_GREEN,
    parameter int YEL_CYCLES = DEF_YEL_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic Ta,
    input  logic Tb,
    input  logic Tal,
    input  logic Tbl,
    output logic q2,
    output logic q1,
    output logic q0,
    output logic st_chg
);

    localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YEL_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             exit_now;
    logic             sensor;
    logic             st_chg_q;

    // The counter restarts on exactly the edge that loads a new state.
    tl_dwell_cnt #(
        .CNT_W (CNT_W)
    ) u_dwell_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (exit_now),
        .cnt     (cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S0;
            st_chg_q <= 1'b0;
        end else begin
            state    <= next_state;
            st_chg_q <= exit_now;
        end
    end

    always_comb begin
        sensor = 1'b0;
        case (state)
            S0:      sensor = Ta;
            S2:      sensor = Tal;
            S4:      sensor = Tb;
            S6:      sensor = Tbl;
            default: sensor = 1'b0;
        endcase

        if (is_yellow(state)) begin
            exit_now = (cnt == YEL_M1);
        end else begin
            exit_now = ((cnt >= MIN_M1) && !sensor) || (cnt == MAX_M1);
        end

        next_state = state;
        if (exit_now) begin
            // Left phases are entered only if there is demand at the yellow exit.
            case (state)
                S0:      next_state = S1;
                S1:      next_state = Tal ? S2 : S4;
                S2:      next_state = S3;
                S3:      next_state = S4;
                S4:      next_state = S5;
                S5:      next_state = Tbl ? S6 : S0;
                S6:      next_state = S7;
                default: next_state = S0;
            endcase
        end
    end

    always_comb begin
        {q2, q1, q0} = state;
        st_chg       = st_chg_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_tl_state_seq.sv
// ============================================================================
// tb_tl_state_seq : scoreboard bench; each st_chg pulse is matched against the
//                   expected new state and the dwell of the state it replaced
// ============================================================================
`default_nettype none

module tb_tl_state_seq;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic Ta = 1'b0, Tb = 1'b0, Tal = 1'b0, Tbl = 1'b0;
    logic q2, q1, q0, st_chg;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        logic [2:0] st;
        int         dwell;
    } exp_t;

    exp_t exp_q[$];
    int   dwell = 0;

    tl_state_seq #(
        .MIN_GREEN  (4),
        .MAX_GREEN  (16),
        .YEL_CYCLES (2),
        .CNT_W      (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Ta      (Ta),
        .Tb      (Tb),
        .Tal     (Tal),
        .Tbl     (Tbl),
        .q2      (q2),
        .q1      (q1),
        .q0      (q0),
        .st_chg  (st_chg)
    );

    always #5 clk = ~clk;

    // Monitor: dwell counts negedges spent in the currently displayed state.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b0) begin
            dwell = 0;
        end else if (st_chg === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_st_chg: got state=%0d after dwell=%0d, required no state change",
                         {q2, q1, q0}, dwell);
            end else begin
                e = exp_q.pop_front();
                if ({q2, q1, q0} !== e.st || dwell != e.dwell) begin
                    fails++;
                    $display("FAIL state_entry @%0t: got state=%0d prev_dwell=%0d, required state=%0d prev_dwell=%0d",
                             $time, {q2, q1, q0}, dwell, e.st, e.dwell);
                end
            end
            dwell = 1;
        end else begin
            dwell++;
        end
    end

    task automatic push(input logic [2:0] s, input int d);
        exp_t e;
        e.st    = s;
        e.dwell = d;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if ({q2, q1, q0} !== 3'b000 || st_chg !== 1'b0) begin
            fails++;
            $display("FAIL %s: got q=%b st_chg=%b, required q=000 st_chg=0",
                     name, {q2, q1, q0}, st_chg);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {Ta, Tb, Tal, Tbl} = 4'b0000;
        tick(1);
        reset_n = 1'b1;
        check_idle("reset_state");
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: got %0d pending state entries, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // No demand: S0 4, S1 2, S4 4, S5 2, repeating every 12 cycles.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push(3'd1, 4); push(3'd4, 2); push(3'd5, 4); push(3'd0, 2);
        end
        tick(25);
        check_drained("idle_loop");

        // Ta held: S0 capped at 16 cycles.
        do_reset();
        Ta = 1'b1;
        push(3'd1, 16); push(3'd4, 2);
        tick(19);
        check_drained("ta_max_green");

        // Ta drops when cnt=7: S0 lasts 8 cycles.
        do_reset();
        Ta = 1'b1;
        push(3'd1, 8); push(3'd4, 2);
        tick(7);
        Ta = 1'b0;
        tick(4);
        check_drained("ta_drop_cnt7");

        // Tal high through S1 exit, dropped at cnt=5 of S2.
        do_reset();
        Tal = 1'b1;
        push(3'd1, 4); push(3'd2, 2); push(3'd3, 6); push(3'd4, 2);
        tick(11);
        Tal = 1'b0;
        tick(4);
        check_drained("left_phase_a");

        // Tal only during S0 and early S1: left phase skipped.
        do_reset();
        Tal = 1'b1;
        push(3'd1, 4); push(3'd4, 2);
        tick(5);
        Tal = 1'b0;
        tick(2);
        check_drained("left_skip_a");

        // All sensors high: full rotation, greens 16, yellows 2.
        do_reset();
        {Ta, Tb, Tal, Tbl} = 4'b1111;
        push(3'd1, 16); push(3'd2, 2); push(3'd3, 16); push(3'd4, 2);
        push(3'd5, 16); push(3'd6, 2); push(3'd7, 16); push(3'd0, 2);
        tick(74);
        check_drained("full_rotation");

        // Reset while in S5 with cnt=1, then S0 holds its full minimum.
        do_reset();
        push(3'd1, 4); push(3'd4, 2); push(3'd5, 4);
        tick(11);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check_idle("reset_mid_yellow");
        push(3'd1, 4); push(3'd4, 2);
        tick(7);
        check_drained("after_mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
